// File: rtl/park_pay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : park_pay_pkg
// Purpose  : Shared states, default coin table and saturating add for payment_collector
// Revision : 1.0
// ============================================================================
package park_pay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PAID    = 2'd2,
    ST_REFUND  = 2'd3
  } pay_state_e;

  // Index 0 is the LSB slice, so selector 0 maps to the rightmost entry.
  localparam logic [31:0] C_COIN_VALUES_DEFAULT = {8'd1, 8'd2, 8'd5, 8'd10};

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          width);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/payment_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : payment_collector_if
// Purpose  : Fare request, coin/card/cancel inputs and payment result outputs
// Revision : 1.0
// ============================================================================
interface payment_collector_if #(
  parameter int SUM_W     = 10,
  parameter int NUM_COINS = 4
);
  localparam int CSEL_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

  logic              start;
  logic [SUM_W-1:0]  fare;
  logic              coin_valid;
  logic [CSEL_W-1:0] coin_sel;
  logic              card_tap;
  logic              cancel;
  logic              busy;
  logic              paid;
  logic [SUM_W-1:0]  change;
  logic              refund_valid;
  logic [SUM_W-1:0]  refund_amt;
  logic [SUM_W-1:0]  current_sum;
  logic [1:0]        state;

  modport master (
    output start, fare, coin_valid, coin_sel, card_tap, cancel,
    input  busy, paid, change, refund_valid, refund_amt, current_sum, state
  );

  modport slave (
    input  start, fare, coin_valid, coin_sel, card_tap, cancel,
    output busy, paid, change, refund_valid, refund_amt, current_sum, state
  );

endinterface
`default_nettype wire

// File: rtl/pay_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : pay_accumulator
// Purpose  : Coin lookup, saturating running sum and inactivity timer
// Revision : 1.0
// ============================================================================
module pay_accumulator
  import park_pay_pkg::*;
#(
  parameter int                       SUM_W       = 10,
  parameter int                       NUM_COINS   = 4,
  parameter logic [NUM_COINS*8-1:0]   COIN_VALUES = C_COIN_VALUES_DEFAULT,
  parameter int                       TIMEOUT_CYC = 1000,
  parameter int                       TMR_W       = 16,
  parameter int                       CSEL_W      = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              enable,
  input  logic              load,
  input  logic [SUM_W-1:0]  load_val,
  input  logic              coin_valid,
  input  logic [CSEL_W-1:0] coin_sel,
  output logic [SUM_W-1:0]  sum,
  output logic [SUM_W-1:0]  sum_next,
  output logic [SUM_W-1:0]  coin_amt,
  output logic              timeout
);

  logic [SUM_W-1:0] r_sum;
  logic [TMR_W-1:0] r_timer;
  logic [7:0]       w_coin_raw;
  logic             w_sel_ok;
  logic             w_accept;

  always_comb begin
    w_coin_raw = 8'd0;
    w_sel_ok   = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_sel == CSEL_W'(i)) begin
        w_sel_ok   = 1'b1;
        w_coin_raw = COIN_VALUES[i*8 +: 8];
      end
    end
  end

  assign w_accept = enable & coin_valid & w_sel_ok;
  assign coin_amt = w_accept ? SUM_W'(sat_add(32'd0, {24'd0, w_coin_raw}, SUM_W)) : '0;
  assign sum_next = SUM_W'(sat_add(32'(r_sum), 32'(coin_amt), SUM_W));
  assign sum      = r_sum;

  // Fires on the cycle whose increment would bring the timer to TIMEOUT_CYC-1.
  assign timeout  = enable & ~w_accept & (r_timer == TMR_W'(TIMEOUT_CYC - 2));

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_sum   <= '0;
      r_timer <= '0;
    end else if (clear) begin
      r_sum   <= '0;
      r_timer <= '0;
    end else if (load) begin
      r_sum   <= load_val;
    end else if (enable) begin
      r_sum   <= sum_next;
      r_timer <= w_accept ? '0 : r_timer + TMR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/payment_collector.sv
`default_nettype none
// ============================================================================
// Module   : payment_collector
// Purpose  : Fare collection FSM with coin/card payment, cancel and timeout refund
// Revision : 1.0
// ============================================================================
module payment_collector
  import park_pay_pkg::*;
#(
  parameter int                       SUM_W       = 10,
  parameter int                       NUM_COINS   = 4,
  parameter logic [NUM_COINS*8-1:0]   COIN_VALUES = C_COIN_VALUES_DEFAULT,
  parameter int                       TIMEOUT_CYC = 1000,
  parameter int                       TMR_W       = 16
) (
  input  logic                clock,
  input  logic                resetn,
  payment_collector_if.slave  bus
);

  localparam int CSEL_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

  pay_state_e       r_state;
  pay_state_e       w_state_next;
  logic [SUM_W-1:0] r_fare;
  logic [SUM_W-1:0] r_change;
  logic [SUM_W-1:0] r_refund_amt;

  logic             w_fare_load;
  logic             w_acc_clear;
  logic             w_acc_en;
  logic             w_acc_load;
  logic             w_change_load;
  logic [SUM_W-1:0] w_change_val;
  logic             w_refund_load;

  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_sum_next;
  logic [SUM_W-1:0] w_coin_amt;
  logic             w_timeout;

  pay_accumulator #(
    .SUM_W       (SUM_W),
    .NUM_COINS   (NUM_COINS),
    .COIN_VALUES (COIN_VALUES),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W),
    .CSEL_W      (CSEL_W)
  ) u_acc (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (w_acc_clear),
    .enable     (w_acc_en),
    .load       (w_acc_load),
    .load_val   (r_fare),
    .coin_valid (bus.coin_valid),
    .coin_sel   (bus.coin_sel),
    .sum        (w_sum),
    .sum_next   (w_sum_next),
    .coin_amt   (w_coin_amt),
    .timeout    (w_timeout)
  );

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_fare_load   = 1'b0;
    w_acc_clear   = 1'b0;
    w_acc_en      = 1'b0;
    w_acc_load    = 1'b0;
    w_change_load = 1'b0;
    w_change_val  = '0;
    w_refund_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_acc_clear = 1'b1;
        if (bus.start) begin
          w_fare_load = 1'b1;
          if (bus.fare == '0) begin
            w_state_next  = ST_PAID;
            w_change_load = 1'b1;
          end else begin
            w_state_next  = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        w_acc_en = 1'b1;
        // Exit priority: cancel, card, sum reached, inactivity.
        if (bus.cancel) begin
          w_state_next  = ST_REFUND;
          w_refund_load = 1'b1;
        end else if (bus.card_tap) begin
          w_state_next  = ST_PAID;
          w_acc_load    = 1'b1;
          w_change_load = 1'b1;
          w_change_val  = w_coin_amt;
        end else if (w_sum >= r_fare) begin
          w_state_next  = ST_PAID;
          w_change_load = 1'b1;
          w_change_val  = w_sum_next - r_fare;
        end else if (w_timeout) begin
          w_state_next  = ST_REFUND;
          w_refund_load = 1'b1;
        end
      end
      ST_PAID: begin
        w_acc_clear  = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_REFUND: begin
        w_acc_clear  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_acc_clear  = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_fare       <= '0;
      r_change     <= '0;
      r_refund_amt <= '0;
    end else begin
      if (w_fare_load)   r_fare       <= bus.fare;
      if (w_change_load) r_change     <= w_change_val;
      if (w_refund_load) r_refund_amt <= w_sum_next;
    end
  end

  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.paid         = (r_state == ST_PAID);
  assign bus.refund_valid = (r_state == ST_REFUND);
  assign bus.change       = r_change;
  assign bus.refund_amt   = r_refund_amt;
  assign bus.current_sum  = w_sum;
  assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_payment_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_payment_collector
// Purpose  : Directed self-checking bench for payment_collector
// Revision : 1.0
// ============================================================================
module tb_payment_collector;

  logic clock = 1'b0;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  // Default table {1,2,5,10}: selector 0 is the LSB slice (value 10).
  localparam logic [1:0] SEL10 = 2'd0;
  localparam logic [1:0] SEL5  = 2'd1;
  localparam logic [1:0] SEL2  = 2'd2;
  localparam logic [1:0] SEL1  = 2'd3;

  payment_collector_if #(.SUM_W(10), .NUM_COINS(4)) bus0 ();
  payment_collector_if #(.SUM_W(10), .NUM_COINS(4)) bus1 ();
  payment_collector_if #(.SUM_W(4),  .NUM_COINS(4)) bus2 ();

  payment_collector u_main (.clock(clock), .resetn(resetn), .bus(bus0.slave));
  payment_collector #(.TIMEOUT_CYC(10)) u_tmo (.clock(clock), .resetn(resetn), .bus(bus1.slave));
  payment_collector #(.SUM_W(4)) u_sat (.clock(clock), .resetn(resetn), .bus(bus2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    bus0.start = 0; bus0.fare = '0; bus0.coin_valid = 0; bus0.coin_sel = '0; bus0.card_tap = 0; bus0.cancel = 0;
    bus1.start = 0; bus1.fare = '0; bus1.coin_valid = 0; bus1.coin_sel = '0; bus1.card_tap = 0; bus1.cancel = 0;
    bus2.start = 0; bus2.fare = '0; bus2.coin_valid = 0; bus2.coin_sel = '0; bus2.card_tap = 0; bus2.cancel = 0;
    resetn = 1'b1;
    repeat (2) tick();
    resetn = 1'b0;
    tick();

    check("rst_state", 32'(bus0.state), 0);
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_paid", 32'(bus0.paid), 0);
    check("rst_refund_valid", 32'(bus0.refund_valid), 0);
    check("rst_sum", 32'(bus0.current_sum), 0);
    check("rst_change", 32'(bus0.change), 0);
    check("rst_refund_amt", 32'(bus0.refund_amt), 0);

    // Inputs other than start are ignored in IDLE
    bus0.coin_valid = 1; bus0.coin_sel = SEL10; bus0.card_tap = 1; bus0.cancel = 1;
    tick();
    bus0.coin_valid = 0; bus0.card_tap = 0; bus0.cancel = 0;
    check("idle_ignore_sum", 32'(bus0.current_sum), 0);
    check("idle_ignore_state", 32'(bus0.state), 0);

    // Exact payment: fare 8, coins 5,2,1
    bus0.start = 1; bus0.fare = 8;
    tick();
    bus0.start = 0;
    check("exact_busy", 32'(bus0.busy), 1);
    check("exact_state_collect", 32'(bus0.state), 1);
    bus0.coin_valid = 1; bus0.coin_sel = SEL5;
    tick();
    check("exact_sum5", 32'(bus0.current_sum), 5);
    bus0.coin_sel = SEL2;
    tick();
    check("exact_sum7", 32'(bus0.current_sum), 7);
    bus0.coin_sel = SEL1;
    tick();
    bus0.coin_valid = 0;
    check("exact_sum8", 32'(bus0.current_sum), 8);
    check("exact_not_paid_yet", 32'(bus0.paid), 0);
    tick();
    check("exact_paid", 32'(bus0.paid), 1);
    check("exact_change", 32'(bus0.change), 0);
    check("exact_state_paid", 32'(bus0.state), 2);
    tick();
    check("exact_paid_drop", 32'(bus0.paid), 0);
    check("exact_busy_drop", 32'(bus0.busy), 0);
    check("exact_sum_clear", 32'(bus0.current_sum), 0);

    // Overpay: fare 3, coin 5
    bus0.start = 1; bus0.fare = 3;
    tick();
    bus0.start = 0; bus0.coin_valid = 1; bus0.coin_sel = SEL5;
    tick();
    bus0.coin_valid = 0;
    tick();
    check("over_paid", 32'(bus0.paid), 1);
    check("over_change", 32'(bus0.change), 2);
    tick();

    // Card: fare 40, coin 2, then card tap
    bus0.start = 1; bus0.fare = 40;
    tick();
    bus0.start = 0; bus0.coin_valid = 1; bus0.coin_sel = SEL2;
    tick();
    bus0.coin_valid = 0; bus0.card_tap = 1;
    check("card_sum2", 32'(bus0.current_sum), 2);
    tick();
    bus0.card_tap = 0;
    check("card_paid", 32'(bus0.paid), 1);
    check("card_change", 32'(bus0.change), 0);
    check("card_sum_fare", 32'(bus0.current_sum), 40);
    check("card_no_refund", 32'(bus0.refund_valid), 0);
    tick();
    check("card_no_refund_after", 32'(bus0.refund_valid), 0);
    check("card_idle", 32'(bus0.busy), 0);

    // Card with a coin in the same cycle returns the coin as change
    bus0.start = 1; bus0.fare = 40;
    tick();
    bus0.start = 0; bus0.card_tap = 1; bus0.coin_valid = 1; bus0.coin_sel = SEL5;
    tick();
    bus0.card_tap = 0; bus0.coin_valid = 0;
    check("card_coin_paid", 32'(bus0.paid), 1);
    check("card_coin_change", 32'(bus0.change), 5);
    tick();

    // Cancel: fare 20, coins 5,5, then cancel with coin 1
    bus0.start = 1; bus0.fare = 20;
    tick();
    bus0.start = 0; bus0.coin_valid = 1; bus0.coin_sel = SEL5;
    tick();
    tick();
    bus0.cancel = 1; bus0.coin_sel = SEL1;
    check("cancel_sum10", 32'(bus0.current_sum), 10);
    tick();
    bus0.cancel = 0; bus0.coin_valid = 0;
    check("cancel_refund_valid", 32'(bus0.refund_valid), 1);
    check("cancel_refund_amt", 32'(bus0.refund_amt), 11);
    check("cancel_state", 32'(bus0.state), 3);
    check("cancel_no_paid", 32'(bus0.paid), 0);
    tick();
    check("cancel_refund_drop", 32'(bus0.refund_valid), 0);
    check("cancel_sum_clear", 32'(bus0.current_sum), 0);

    // Zero fare completes the cycle after start
    bus0.start = 1; bus0.fare = 0;
    tick();
    bus0.start = 0;
    check("zero_paid", 32'(bus0.paid), 1);
    check("zero_change", 32'(bus0.change), 0);
    tick();
    check("zero_idle", 32'(bus0.busy), 0);

    // Start while busy must not re-sample fare
    bus0.start = 1; bus0.fare = 50;
    tick();
    bus0.fare = 1;
    tick();
    bus0.start = 0; bus0.coin_valid = 1; bus0.coin_sel = SEL10;
    tick();
    bus0.coin_valid = 0;
    tick();
    check("resample_not_paid", 32'(bus0.paid), 0);
    check("resample_state", 32'(bus0.state), 1);
    bus0.cancel = 1;
    tick();
    bus0.cancel = 0;
    check("resample_refund_amt", 32'(bus0.refund_amt), 10);
    tick();

    // Timeout at 10 cycles: fare 9, single coin 2
    bus1.start = 1; bus1.fare = 9;
    tick();
    bus1.start = 0; bus1.coin_valid = 1; bus1.coin_sel = SEL2;
    tick();
    bus1.coin_valid = 0;
    repeat (8) tick();
    check("tmo_not_yet", 32'(bus1.refund_valid), 0);
    check("tmo_still_collect", 32'(bus1.state), 1);
    tick();
    check("tmo_refund_valid", 32'(bus1.refund_valid), 1);
    check("tmo_refund_amt", 32'(bus1.refund_amt), 2);
    tick();
    check("tmo_idle", 32'(bus1.busy), 0);

    // Saturation with SUM_W=4: fare 15, coins 10,10
    bus2.start = 1; bus2.fare = 15;
    tick();
    bus2.start = 0; bus2.coin_valid = 1; bus2.coin_sel = SEL10;
    tick();
    tick();
    bus2.coin_valid = 0;
    check("sat_sum15", 32'(bus2.current_sum), 15);
    tick();
    check("sat_paid", 32'(bus2.paid), 1);
    check("sat_change", 32'(bus2.change), 0);
    tick();

    // Saturation with SUM_W=4: fare 15, four coins of 5 back to back
    bus2.start = 1; bus2.fare = 15;
    tick();
    bus2.start = 0; bus2.coin_valid = 1; bus2.coin_sel = SEL5;
    repeat (3) tick();
    check("sat4_sum15", 32'(bus2.current_sum), 15);
    tick();
    bus2.coin_valid = 0;
    check("sat4_paid", 32'(bus2.paid), 1);
    check("sat4_change", 32'(bus2.change), 0);
    check("sat4_sum_held", 32'(bus2.current_sum), 15);
    tick();

    // Asynchronous reset mid-COLLECT
    bus0.start = 1; bus0.fare = 30;
    tick();
    bus0.start = 0; bus0.coin_valid = 1; bus0.coin_sel = SEL5;
    tick();
    bus0.coin_valid = 0;
    check("mid_rst_sum_before", 32'(bus0.current_sum), 5);
    #2 resetn = 1'b1;
    #1;
    check("mid_rst_state", 32'(bus0.state), 0);
    check("mid_rst_sum", 32'(bus0.current_sum), 0);
    check("mid_rst_busy", 32'(bus0.busy), 0);
    tick();
    check("mid_rst_no_refund", 32'(bus0.refund_valid), 0);
    check("mid_rst_no_paid", 32'(bus0.paid), 0);
    resetn = 1'b0;
    tick();
    check("post_rst_state", 32'(bus0.state), 0);
    check("post_rst_no_refund", 32'(bus0.refund_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/payment_collector.md
Name: payment_collector

Overview:
- Parametrised successor to the single-channel parking vending control/datapath pair.
- Accepts a fare request from the spot/rate logic, collects coins of `NUM_COINS` configurable denominations or a card tap, and completes with a paid pulse plus change amount.
- Adds what the earlier block lacks: cancel/timeout with full refund, and a saturating accumulator of parametrised width.
- Sits between rate conversion and spot-update logic.

Parameters:
- `SUM_W`, 10, width of fare, sum, change and refund values.
- `NUM_COINS`, 4, number of accepted denominations.
- `COIN_VALUES`, {8'd1,8'd2,8'd5,8'd10}, packed `NUM_COINS`x8 denomination table; index 0 is the LSB slice.
- `TIMEOUT_CYC`, 1000, idle cycles in COLLECT before automatic refund; minimum 2.
- `TMR_W`, 16, timeout counter width; must satisfy 2^`TMR_W` > `TIMEOUT_CYC`.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; `fare` sampled the same cycle.
- `fare`  in  `SUM_W`  amount due.
- `coin_valid`  in  1  one-cycle coin insertion strobe.
- `coin_sel`  in  $clog2(`NUM_COINS`)  denomination index; valid when `coin_valid`.
- `card_tap`  in  1  card payment strobe.
- `cancel`  in  1  user abort strobe.
- `busy`  out  1  high in any state other than IDLE.
- `paid`  out  1  one-cycle completion pulse.
- `change`  out  `SUM_W`  sum minus fare; valid while `paid`.
- `refund_valid`  out  1  one-cycle refund pulse.
- `refund_amt`  out  `SUM_W`  amount refunded; valid while `refund_valid`.
- `current_sum`  out  `SUM_W`  running total, for display.
- `state`  out  2  encoded FSM state.

Behaviour:
- States: IDLE=0, COLLECT=1, PAID=2, REFUND=3.
- Reset: state=IDLE; sum, fare register, timer, `change` and `refund_amt` all cleared; `paid`=0, `refund_valid`=0, `busy`=0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- IDLE:
  - `start` latches `fare`, clears sum and timer, and moves to COLLECT.
  - If `fare`==0, the next state is PAID instead, with `change`=0.
  - `coin_valid`, `card_tap` and `cancel` in IDLE are ignored; the sum stays 0.
- COLLECT, coin accumulation:
  - Each `coin_valid` adds COIN_VALUES[`coin_sel`] to the sum next cycle.
  - The add saturates at 2^`SUM_W`-1.
  - A `coin_sel` >= `NUM_COINS` is ignored and does not reset the timer.
  - Each accepted coin clears the timer; otherwise the timer increments every cycle.
- COLLECT, exit conditions (priority order):
  - `cancel` → REFUND. Any coin accepted in the same cycle is included in the refund.
  - `card_tap` → PAID with sum := fare and `change`=0. Coins in the same cycle are refunded through `change`, i.e. `change` = coin value.
  - Post-update sum >= fare → PAID, with `change` = sum - fare. This is evaluated on the updated sum, so the transition occurs the cycle after the qualifying coin.
  - Timer reaches `TIMEOUT_CYC`-1 with no coin → REFUND.
- PAID: `paid`=1 and `change` valid for exactly one cycle, then IDLE. `start` is ignored.
- REFUND: `refund_valid`=1 and `refund_amt`=sum for one cycle, then IDLE. A sum of 0 is still pulsed.
- After PAID or REFUND, the sum clears on entry to IDLE.
- `start` while `busy` is ignored, and `fare` is not re-sampled.
- An asynchronous reset mid-transaction discards the sum without a refund pulse.
- Latencies:
  - `start` → `busy` high: 1 cycle.
  - Final coin → `paid`: 2 cycles (sum update, then PAID).

Decomposition:
- Package `park_pay_pkg`:
  - State enum/localparams (IDLE, COLLECT, PAID, REFUND).
  - Default `COIN_VALUES` table.
  - Saturating-add function.
- One sub-module, `pay_accumulator`:
  - Sum register with clear, coin lookup, saturating add and timer.
  - FSM and exit logic live in the top.

Test Plan:
- Exact payment: `fare`=8; coins 5,2,1 on separate cycles → `paid` 2 cycles after the last coin, `change`=0, `busy` drops the next cycle.
- Overpay: `fare`=3; coin 5 → `paid`=1, `change`=2.
- Card: `fare`=40; coin 2, then `card_tap` → `paid`, `change`=0, `refund_valid` never asserted.
- Cancel: `fare`=20; coins 5,5, then `cancel` together with coin 1 → `refund_valid`=1, `refund_amt`=11.
- Timeout: `TIMEOUT_CYC`=10; `fare`=9; one coin 2 and then no more input → `refund_amt`=2 exactly 10 cycles after the coin.
- Edge cases:
  - `SUM_W`=4; `fare`=15, four coins of 5 → sum saturates at 15 and `paid` fires with `change`=0.
  - `fare`=0 → `paid` the cycle after `start`.
  - Reset asserted mid-COLLECT → state IDLE and sum 0 immediately, with no pulses.
